// File: rtl/acc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the double-accumulator
// processor. Drives the PC, IR and accumulator write strobes, the ALU op
// select and a req/ack memory port, and keeps its own copy of the opcode.
// Optional feature: define SINGLE_STEP_EN to add a `step` input and a STEP
// state that pauses the sequencer after every executed instruction.
module acc_control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] mem_rdata_op,
  input  logic       mem_ack,
  input  logic       zero_flag,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       reg_write,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       halted,
  output logic       fault
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS_MEM = 3'd0;
  localparam logic [2:0] ALU_ADD      = 3'd1;
  localparam logic [2:0] ALU_SUB      = 3'd2;
  localparam logic [2:0] ALU_AND      = 3'd3;
  localparam logic [2:0] ALU_PASS_IMM = 3'd4;

  // Timeout counter only needs to reach MEM_TIMEOUT; keep at least one bit.
  localparam int             CW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(MEM_TIMEOUT);
  localparam bit             TO_EN     = (MEM_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
`ifdef SINGLE_STEP_EN
    ,
    S_STEP   = 3'd7
`endif
  } state_t;

  // Where an instruction goes once it has finished in EXEC or MEM.
`ifdef SINGLE_STEP_EN
  localparam state_t S_AFTER_OP = S_STEP;
`else
  localparam state_t S_AFTER_OP = S_FETCH;
`endif

  state_t        state_q, state_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed_out;

  // A memory wait expires only when the limit is reached with no ack this cycle.
  assign timed_out = TO_EN && (cnt_q == CNT_LIMIT) && !mem_ack;

  // State, latched opcode and timeout counter; reset returns to IDLE at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_NOP;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would create order-dependent races.
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state decode and Moore/Mealy strobe generation.
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    opcode_d  = opcode_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_op    = ALU_PASS_MEM;
    busy      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          opcode_d = mem_rdata_op;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        case (opcode_q)
          OP_NOP, OP_ADD, OP_SUB, OP_AND,
          OP_LDI, OP_JMP, OP_BZ:          state_d = S_EXEC;
          OP_LD, OP_ST: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          OP_HALT:                        state_d = S_HALT;
          default:                        state_d = S_FAULT;
        endcase
      end

      S_EXEC: begin
        busy = 1'b1;
        case (opcode_q)
          OP_ADD: begin alu_op = ALU_ADD;      reg_write = 1'b1; end
          OP_SUB: begin alu_op = ALU_SUB;      reg_write = 1'b1; end
          OP_AND: begin alu_op = ALU_AND;      reg_write = 1'b1; end
          OP_LDI: begin alu_op = ALU_PASS_IMM; reg_write = 1'b1; end
          OP_JMP: pc_write = 1'b1;
          OP_BZ:  pc_write = zero_flag;
          default: ;
        endcase
        state_d = S_AFTER_OP;
        cnt_d   = '0;
      end

      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (opcode_q == OP_ST);
        if (mem_ack) begin
          if (opcode_q == OP_LD) begin
            alu_op    = ALU_PASS_MEM;
            reg_write = 1'b1;
          end
          state_d = S_AFTER_OP;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      S_FAULT: begin
        fault = 1'b1;
      end

`ifdef SINGLE_STEP_EN
      S_STEP: begin
        busy = 1'b1;
        if (step) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// Self-checking bench for acc_control_unit: a table of instructions with
// their expected execute-stage strobes, queued on issue and compared when the
// sequencer reaches the execute or memory-complete cycle, plus hand-written
// sequences for reset, timeout, illegal opcode and HALT/resume.
module tb_acc_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [3:0] mem_rdata_op;
  logic       mem_ack;
  logic       zero_flag;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic       mem_req, mem_we, mem_sel, ir_write, pc_inc, pc_write, reg_write;
  logic [2:0] alu_op;
  logic       busy, halted, fault;

  acc_control_unit #(.MEM_TIMEOUT(15)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .mem_rdata_op (mem_rdata_op),
    .mem_ack      (mem_ack),
    .zero_flag    (zero_flag),
`ifdef SINGLE_STEP_EN
    .step         (step),
`endif
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .ir_write     (ir_write),
    .pc_inc       (pc_inc),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_op       (alu_op),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    int         fw;   // fetch wait cycles before ack
    int         mw;   // memory wait cycles before ack (LD/ST only)
    logic       zf;
    logic       rw;   // expected reg_write on result cycle
    logic [2:0] alu;  // expected alu_op on result cycle
    logic       pcw;  // expected pc_write on result cycle
    logic       we;   // expected mem_we during MEM
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [12:0] pack_out();
    return {mem_req, mem_we, mem_sel, ir_write, pc_inc, pc_write, reg_write,
            alu_op, busy, halted, fault};
  endfunction

  function automatic logic [12:0] ov(input int req, input int we, input int sel,
                                     input int irw, input int pci, input int pcw,
                                     input int rw, input int alu, input int bsy,
                                     input int hlt, input int flt);
    logic [2:0] a;
    a = alu[2:0];
    return {req[0], we[0], sel[0], irw[0], pci[0], pcw[0], rw[0], a,
            bsy[0], hlt[0], flt[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Fetch (with fw wait cycles) and decode; leaves the DUT just past DECODE.
  task automatic fetch_decode(input logic [3:0] op, input int fw);
    for (int w = 0; w <= fw; w++) begin
      mem_ack      = (w == fw);
      mem_rdata_op = (w == fw) ? op : 4'hE;
      @(negedge CLK);
      check("fetch", pack_out(), ov(1, 0, 0, int'(w == fw), int'(w == fw), 0, 0, 0, 1, 0, 0));
      tick();
    end
    mem_ack      = 1'b0;
    mem_rdata_op = 4'h0;
    @(negedge CLK);
    check("decode", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
  endtask

  // One complete instruction from FETCH back to FETCH.
  task automatic run_instr(input vec_t v);
    vec_t e;
    sb.push_back(v);
    fetch_decode(v.op, v.fw);
    if (v.op == 4'h5 || v.op == 4'h6) begin
      for (int w = 0; w <= v.mw; w++) begin
        mem_ack = (w == v.mw);
        @(negedge CLK);
        if (w == v.mw) begin
          e = sb.pop_front();
          check("mem_done", pack_out(), ov(1, int'(e.we), 1, 0, 0, int'(e.pcw), int'(e.rw),
                                           int'(e.alu), 1, 0, 0));
        end else begin
          check("mem_wait", pack_out(), ov(1, int'(v.we), 1, 0, 0, 0, 0, 0, 1, 0, 0));
        end
        tick();
      end
      mem_ack = 1'b0;
    end else begin
      zero_flag = v.zf;
      @(negedge CLK);
      e = sb.pop_front();
      check("exec", pack_out(), ov(0, 0, 0, 0, 0, int'(e.pcw), int'(e.rw), int'(e.alu), 1, 0, 0));
      tick();
      zero_flag = ~v.zf;
    end
`ifdef SINGLE_STEP_EN
    step = 1'b0;
    @(negedge CLK);
    check("step_stall", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    step = 1'b1;
    @(negedge CLK);
    check("step_go", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    step = 1'b0;
`endif
  endtask

  task automatic reset_and_start();
    RST = 1'b0;
    tick();
    RST   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //                op    fw mw zf    rw    alu   pcw   we
    vecs[0]  = '{4'h1, 0, 0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0}; // ADD, zero-wait
    vecs[1]  = '{4'h2, 2, 0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0}; // SUB
    vecs[2]  = '{4'h3, 1, 0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0}; // AND
    vecs[3]  = '{4'h4, 0, 0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0}; // LDI
    vecs[4]  = '{4'h0, 0, 0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}; // NOP
    vecs[5]  = '{4'h7, 0, 0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}; // JMP
    vecs[6]  = '{4'h8, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // BZ not taken
    vecs[7]  = '{4'h8, 1, 0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0}; // BZ taken
    vecs[8]  = '{4'h5, 0, 3, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}; // LD, mem wait 3
    vecs[9]  = '{4'h6, 0, 1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1}; // ST
    vecs[10] = '{4'h5, 2, 0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}; // LD zero mem wait
    vecs[11] = '{4'h6, 0, 0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1}; // ST zero wait

    RST = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rdata_op = 4'h0; zero_flag = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    #1;
    check("reset_outputs", pack_out(), 13'h0);
    repeat (2) tick();
    RST = 1'b1;

    // IDLE ignores mem_ack and stays quiet without start.
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("idle", pack_out(), 13'h0);
      tick();
    end
    mem_ack = 1'b0;

    // Asynchronous reset in the middle of a fetch drops mem_req at once.
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge CLK);
    check("fetch_before_rst", pack_out(), ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    #2;
    RST = 1'b0;
    #1;
    check("async_rst", pack_out(), 13'h0);
    tick();
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("idle_after_rst", pack_out(), 13'h0);
      tick();
    end

    // Instruction table; start is held high throughout and must be ignored.
    start = 1'b1;
    tick();
    foreach (vecs[i]) run_instr(vecs[i]);
    start = 1'b0;
    check("sb_empty", sb.size(), 0);

    // Fetch timeout: 16 cycles without ack, then FAULT.
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      check("fetch_to_wait", pack_out(), ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      tick();
    end
    @(negedge CLK);
    check("fetch_timeout", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // FAULT is sticky against start and ack.
    start = 1'b1; mem_ack = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    check("fault_sticky", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    start = 1'b0; mem_ack = 1'b0;
    tick();

    // Ack on the 16th fetch cycle wins over the limit.
    reset_and_start();
    run_instr('{4'h0, 15, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    @(negedge CLK);
    check("no_fault_ack16", pack_out(), ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();

    // Memory timeout during LD.
    reset_and_start();
    fetch_decode(4'h5, 0);
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      check("mem_to_wait", pack_out(), ov(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tick();
    end
    @(negedge CLK);
    check("mem_timeout", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick();

    // Illegal opcode A faults right after DECODE.
    reset_and_start();
    fetch_decode(4'hA, 0);
    @(negedge CLK);
    check("illegal_op", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick();

    // HALT, wait, then resume with start.
    reset_and_start();
    fetch_decode(4'hF, 1);
    repeat (2) begin
      @(negedge CLK);
      check("halted", pack_out(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr('{4'h1, 0, 0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
    @(negedge CLK);
    check("resume_fetch", pack_out(), ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
